// File: rtl/bar_meter_peak.sv
// bar_meter_peak: bar-graph level meter with smoothing, peak hold and pixel classification.
// Ports: CLK_VGA/RESET_N clock and async active-low reset; sample_valid/wave_sample capture
// samples round-robin into bins; tick advances smoothing/peak for one bar; fast_attack selects
// instant rise; freeze suspends capture and update; VGA_HORZ_COORD/VGA_VERT_COORD address the
// pixel; bar_on/peak_on/cell_row are the registered classification of that pixel.
module bar_meter_peak #(
    parameter int NUM_BARS   = 80,
    parameter int SAMPLE_W   = 10,
    parameter int LEVEL_W    = 5,
    parameter int COL_LOG2   = 4,
    parameter int ROW_LOG2   = 4,
    parameter int BASE_Y     = 512,
    parameter int HOLD_TICKS = 24
) (
    input  logic                CLK_VGA,
    input  logic                RESET_N,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] wave_sample,
    input  logic                tick,
    input  logic                fast_attack,
    input  logic                freeze,
    input  logic [11:0]         VGA_HORZ_COORD,
    input  logic [11:0]         VGA_VERT_COORD,
    output logic                bar_on,
    output logic                peak_on,
    output logic [LEVEL_W-1:0]  cell_row
);
    localparam int PW = NUM_BARS > 1 ? $clog2(NUM_BARS) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_BARS - 1);
    localparam logic [11:0] LMAX12 = 12'((1 << LEVEL_W) - 1);
    localparam logic [11:0] NB12 = 12'(NUM_BARS);
    localparam logic [11:0] BASE12 = 12'(BASE_Y);
    localparam logic [7:0] HOLD8 = 8'(HOLD_TICKS);
    logic [LEVEL_W-1:0] target [NUM_BARS];
    logic [LEVEL_W-1:0] level [NUM_BARS];
    logic [LEVEL_W-1:0] peak [NUM_BARS];
    logic [7:0]         hold [NUM_BARS];
    logic [PW-1:0]      wp, up, ci;
    logic [LEVEL_W-1:0] cur_t, cur_l, cur_p, new_l, new_t;
    logic [11:0]        col, dy, row;
    logic               valid, grid, unused_ok;
    assign cur_t = target[up];
    assign cur_l = level[up];
    assign cur_p = peak[up];
    assign new_l = cur_t > cur_l ? (fast_attack ? cur_t : cur_l + 1'b1) :
                   cur_t < cur_l ? cur_l - 1'b1 : cur_l;
    assign new_t = wave_sample[SAMPLE_W-1] ? wave_sample[SAMPLE_W-2 -: LEVEL_W] : '0;
    assign col   = VGA_HORZ_COORD >> COL_LOG2;
    assign dy    = BASE12 - VGA_VERT_COORD;
    assign row   = dy >> ROW_LOG2;
    assign valid = VGA_VERT_COORD <= BASE12 && col < NB12 && row <= LMAX12;
    // Out-of-range columns are masked by valid; steer the lookup to bar 0 to stay in bounds.
    assign ci    = valid ? col[PW-1:0] : '0;
    assign grid  = VGA_HORZ_COORD[COL_LOG2-1:0] == '0 || VGA_VERT_COORD[ROW_LOG2-1:0] == '0;
    assign unused_ok = ^{wave_sample, col, dy, row};
    // Nonblocking writes make a same-bar capture/update collision use the old target.
    always_ff @(posedge CLK_VGA or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                target[i] <= '0;
                level[i]  <= '0;
                peak[i]   <= '0;
                hold[i]   <= '0;
            end
            wp <= '0;
            up <= '0;
        end else begin
            if (sample_valid && !freeze) begin
                target[wp] <= new_t;
                wp <= wp == LAST ? '0 : wp + 1'b1;
            end
            if (tick && !freeze) begin
                level[up] <= new_l;
                if (new_l >= cur_p) begin
                    peak[up] <= new_l;
                    hold[up] <= HOLD8;
                end else if (hold[up] != '0) begin
                    hold[up] <= hold[up] - 1'b1;
                end else if (cur_p != '0) begin
                    peak[up] <= cur_p - 1'b1;
                end
                up <= up == LAST ? '0 : up + 1'b1;
            end
        end
    end
    always_ff @(posedge CLK_VGA or negedge RESET_N) begin
        if (!RESET_N) begin
            bar_on   <= 1'b0;
            peak_on  <= 1'b0;
            cell_row <= '0;
        end else begin
            bar_on   <= valid && !grid && row[LEVEL_W-1:0] <= level[ci];
            peak_on  <= valid && !grid && row[LEVEL_W-1:0] == peak[ci] && peak[ci] != '0;
            cell_row <= VGA_VERT_COORD[ROW_LOG2+LEVEL_W-1:ROW_LOG2];
        end
    end
endmodule

// File: tb/tb_bar_meter_peak.sv
// tb_bar_meter_peak: randomized bench for bar_meter_peak against an integer reference model.
module tb_bar_meter_peak;
    logic       clk = 0, rst_n = 0, sv = 0, tk = 0, fa = 0, fr = 0;
    logic [9:0] smp = 0;
    logic [11:0] hc = 0, vc = 0;
    logic       bar_on, peak_on;
    logic [4:0] cell_row;
    int n_chk = 0, n_pass = 0;
    int m_t[80], m_l[80], m_p[80], m_h[80];
    int m_wp, m_up;
    always #5 clk = ~clk;
    bar_meter_peak dut (
        .CLK_VGA(clk), .RESET_N(rst_n), .sample_valid(sv), .wave_sample(smp), .tick(tk),
        .fast_attack(fa), .freeze(fr), .VGA_HORZ_COORD(hc), .VGA_VERT_COORD(vc),
        .bar_on(bar_on), .peak_on(peak_on), .cell_row(cell_row)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask
    function automatic void m_reset();
        for (int i = 0; i < 80; i++) begin
            m_t[i] = 0; m_l[i] = 0; m_p[i] = 0; m_h[i] = 0;
        end
        m_wp = 0;
        m_up = 0;
    endfunction
    task automatic step(input bit s, input logic [9:0] x, input bit t, input bit f, input bit z,
                        input int h, input int v);
        int col, row, nl;
        bit vld, grid;
        logic eb, ep;
        logic [4:0] ec;
        @(negedge clk);
        sv = s; smp = x; tk = t; fa = f; fr = z; hc = 12'(h); vc = 12'(v);
        col  = h / 16;
        row  = (512 - v) / 16;
        vld  = v <= 512 && col < 80 && row <= 31;
        grid = (h % 16 == 0) || (v % 16 == 0);
        eb = vld && !grid && row <= m_l[col];
        ep = vld && !grid && row == m_p[col] && m_p[col] != 0;
        ec = 5'((v / 16) % 32);
        if (t && !z) begin
            nl = m_l[m_up];
            if (m_t[m_up] > nl) nl = f ? m_t[m_up] : nl + 1;
            else if (m_t[m_up] < nl) nl = nl - 1;
            m_l[m_up] = nl;
            if (nl >= m_p[m_up]) begin
                m_p[m_up] = nl;
                m_h[m_up] = 24;
            end else if (m_h[m_up] > 0) m_h[m_up]--;
            else if (m_p[m_up] > 0) m_p[m_up]--;
            m_up = (m_up + 1) % 80;
        end
        if (s && !z) begin
            m_t[m_wp] = x[9] ? int'(x[8:4]) : 0;
            m_wp = (m_wp + 1) % 80;
        end
        @(posedge clk);
        #1;
        chk("bar_on", bar_on, eb);
        chk("peak_on", peak_on, ep);
        chk("cell_row", cell_row, ec);
        sv = 0; tk = 0;
    endtask
    task automatic rstep(input bit s, input logic [9:0] x, input bit t, input bit f, input bit z);
        step(s, x, t, f, z, int'($urandom_range(0, 1300)), int'($urandom_range(0, 540)));
    endtask
    initial begin
        int hv[8][2] = '{'{50, 440}, '{48, 440}, '{1280, 440}, '{50, 520},
                         '{50, 512}, '{1279, 9}, '{55, 504}, '{50, 432}};
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_bar_on", bar_on, 0);
        chk("rst_peak_on", peak_on, 0);
        chk("rst_cell_row", cell_row, 0);
        rst_n = 1;
        for (int i = 0; i < 80; i++) rstep(1, 10'h3F0, 0, 0, 0);
        for (int i = 0; i < 80 * 31; i++) rstep(0, 0, 1, 0, 0);
        for (int b = 0; b < 80; b++) step(0, 0, 1, 0, 0, b * 16 + 8, 8);
        step(0, 0, 0, 0, 0, 8, 504);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_bar_on", bar_on, 0);
        chk("mid_rst_peak_on", peak_on, 0);
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        step(1, 10'h3F0, 1, 1, 0, 8, 488);
        step(0, 0, 0, 0, 0, 8, 488);
        for (int i = 0; i < 79; i++) rstep(1, 10'h340, 0, 0, 0);
        for (int i = 0; i < 80; i++) rstep(0, 0, 1, 1, 0);
        for (int i = 0; i < 80; i++) rstep(1, 10'h1FF, 0, 0, 0);
        for (int i = 0; i < 80 * 50; i++) rstep(0, 0, 1, 0, 0);
        for (int i = 0; i < 80; i++) rstep(1, 10'h2F0, 0, 0, 0);
        for (int i = 0; i < 400; i++) rstep(0, 0, 1, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, hv[i][0], hv[i][1]);
        for (int i = 0; i < 4000; i++)
            rstep(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
